draw_request_arbiter: RTL and testbench

- Shares the single VGA pixel-write path (oX/oY/oColour/oPlot into the VGA adapter) between several highlight requesters: note key, octave button, ADSR button, erase/clear.
- Each requester asks for a BOX_W x BOX_H box at its origin in its colour.
- The block picks one requester round-robin, latches that requester's box, then emits one pixel per clock until the box is done.
- Pixels outside the visible screen are suppressed.

---
 rtl/draw_request_arbiter.sv | 174 +++++++++++++++++
 tb/tb_draw_request_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_request_arbiter.sv
// draw_request_arbiter: round-robin owner of the single VGA pixel-write path.
// A granted requester's box origin and colour are latched, then the box is
// emitted one pixel per clock in row-major order, with off-screen pixels
// suppressed. All outputs are registered.
module draw_request_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BOX_W = 4,
    parameter int unsigned BOX_H = 4,
    parameter int unsigned X_MAX = 320,
    parameter int unsigned Y_MAX = 240
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [NREQ-1:0]   iReq,
    input  logic [9*NREQ-1:0] iX,
    input  logic [8*NREQ-1:0] iY,
    input  logic [3*NREQ-1:0] iColour,
    output logic [NREQ-1:0]   oGrant,
    output logic [8:0]        oX,
    output logic [7:0]        oY,
    output logic [2:0]        oColour,
    output logic              oPlot,
    output logic              oBusy,
    output logic              oDone
);

    localparam int unsigned NPIX = BOX_W * BOX_H;
    localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned LW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StIdle, StDraw} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [8:0]      base_x_q, base_x_d;
    logic [7:0]      base_y_q, base_y_d;
    logic [2:0]      base_colour_q, base_colour_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [8:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [LW-1:0]   win_idx;
    logic            win_found;
    logic [31:0]     search_idx;
    logic [31:0]     cnt_ext;
    logic [31:0]     x_sum32;
    logic [31:0]     y_sum32;
    logic [9:0]      x_sum;
    logic [8:0]      y_sum;
    logic            in_view;

    // Round-robin search: first set request after the last winner, modulo NREQ.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        search_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            search_idx = {{(32-LW){1'b0}}, last_q} + k;
            if (search_idx >= NREQ) begin
                search_idx = search_idx - NREQ;
            end
            if (!win_found && iReq[LW'(search_idx)]) begin
                win_found = 1'b1;
                win_idx   = LW'(search_idx);
            end
        end
    end

    // Pixel address; sums are kept one bit wider so a wrapped pixel fails the
    // visibility compare instead of landing at the left/top edge.
    always_comb begin
        cnt_ext = {{(32-CW){1'b0}}, cnt_q};
        x_sum32 = {23'd0, base_x_q} + (cnt_ext % BOX_W);
        y_sum32 = {24'd0, base_y_q} + (cnt_ext / BOX_W);
        x_sum   = x_sum32[9:0];
        y_sum   = y_sum32[8:0];
        in_view = (x_sum < 10'(X_MAX)) && (y_sum < 9'(Y_MAX));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        base_x_d      = base_x_q;
        base_y_d      = base_y_q;
        base_colour_d = base_colour_q;
        grant_d       = '0;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;
        plot_d        = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    cnt_d            = '0;
                    busy_d           = 1'b1;
                    state_d          = StDraw;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (LW'(i) == win_idx) begin
                            base_x_d      = iX[9*i +: 9];
                            base_y_d      = iY[8*i +: 8];
                            base_colour_d = iColour[3*i +: 3];
                        end
                    end
                end
            end
            StDraw: begin
                x_d      = x_sum[8:0];
                y_d      = y_sum[7:0];
                colour_d = base_colour_q;
                plot_d   = in_view;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(NPIX - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any box in flight.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q       <= StIdle;
            last_q        <= LW'(NREQ - 1);
            cnt_q         <= '0;
            base_x_q      <= '0;
            base_y_q      <= '0;
            base_colour_q <= '0;
            grant_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            base_x_q      <= base_x_d;
            base_y_q      <= base_y_d;
            base_colour_q <= base_colour_d;
            grant_q       <= grant_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign oGrant  = grant_q;
    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed bench for draw_request_arbiter: single box, round-robin order,
// fairness, clipping, wrap suppression and mid-box reset.
module tb_draw_request_arbiter;

    localparam int NREQ = 4;

    logic              iClock;
    logic              iReset;
    logic [NREQ-1:0]   iReq;
    logic [9*NREQ-1:0] iX;
    logic [8*NREQ-1:0] iY;
    logic [3*NREQ-1:0] iColour;
    logic [NREQ-1:0]   oGrant;
    logic [8:0]        oX;
    logic [7:0]        oY;
    logic [2:0]        oColour;
    logic              oPlot;
    logic              oBusy;
    logic              oDone;

    int checks;
    int failures;

    draw_request_arbiter #(
        .NREQ (4),
        .BOX_W(4),
        .BOX_H(4),
        .X_MAX(320),
        .Y_MAX(240)
    ) dut (
        .iClock (iClock),
        .iReset (iReset),
        .iReq   (iReq),
        .iX     (iX),
        .iY     (iY),
        .iColour(iColour),
        .oGrant (oGrant),
        .oX     (oX),
        .oY     (oY),
        .oColour(oColour),
        .oPlot  (oPlot),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic set_box(input int i, input int x, input int y, input int c);
        iX[9*i +: 9]      = 9'(x);
        iY[8*i +: 8]      = 8'(y);
        iColour[3*i +: 3] = 3'(c);
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
    endtask

    // Expect a grant to `who` on the next edge, then its 16 pixels.
    task automatic expect_box(input int who, input int bx, input int by, input int c,
                              input logic [NREQ-1:0] req_after);
        int x, y;
        logic p;
        tick();
        check("grant", 32'(oGrant), 32'(1 << who));
        check("gap_plot", 32'(oPlot), 32'd0);
        check("grant_busy", 32'(oBusy), 32'd1);
        iReq = req_after;
        for (int k = 0; k < 16; k++) begin
            tick();
            x = bx + (k % 4);
            y = by + (k / 4);
            p = (x < 320) && (y < 240);
            check("pix_plot", 32'(oPlot), 32'(p));
            check("pix_x", 32'(oX), 32'(x % 512));
            check("pix_y", 32'(oY), 32'(y % 256));
            check("pix_col", 32'(oColour), 32'(c));
            check("pix_done", 32'(oDone), 32'(k == 15));
            check("pix_busy", 32'(oBusy), 32'(k != 15));
            check("pix_grant", 32'(oGrant), 32'd0);
        end
    endtask

    task automatic expect_idle();
        tick();
        check("idle_grant", 32'(oGrant), 32'd0);
        check("idle_plot", 32'(oPlot), 32'd0);
        check("idle_busy", 32'(oBusy), 32'd0);
        check("idle_done", 32'(oDone), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        iReset   = 1'b1;
        iReq     = '0;
        iX       = '0;
        iY       = '0;
        iColour  = '0;
        #2;
        check("rst_grant", 32'(oGrant), 32'd0);
        check("rst_plot", 32'(oPlot), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_xy", 32'({oX, oY, oColour}), 32'd0);
        tick();
        iReset = 1'b0;

        // Single box; inputs changed after grant must not matter.
        set_box(0, 66, 124, 6);
        iReq = 4'b0001;
        tick();
        check("s_grant", 32'(oGrant), 32'b0001);
        iReq = 4'b0000;
        set_box(0, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("s_plot", 32'(oPlot), 32'd1);
            check("s_x", 32'(oX), 32'(66 + k % 4));
            check("s_y", 32'(oY), 32'(124 + k / 4));
            check("s_col", 32'(oColour), 32'd6);
            check("s_done", 32'(oDone), 32'(k == 15));
        end
        expect_idle();

        // Round robin from reset: 0,1,2,3.
        do_reset();
        set_box(0, 10, 20, 1);
        set_box(1, 30, 40, 2);
        set_box(2, 50, 60, 3);
        set_box(3, 70, 80, 4);
        iReq = 4'b1111;
        expect_box(0, 10, 20, 1, 4'b1110);
        expect_box(1, 30, 40, 2, 4'b1100);
        expect_box(2, 50, 60, 3, 4'b1000);
        expect_box(3, 70, 80, 4, 4'b0000);
        expect_idle();

        // Make last=1, then 1011 -> 3,0,1.
        do_reset();
        iReq = 4'b0010;
        expect_box(1, 30, 40, 2, 4'b0000);
        iReq = 4'b1011;
        expect_box(3, 70, 80, 4, 4'b0011);
        expect_box(0, 10, 20, 1, 4'b0010);
        expect_box(1, 30, 40, 2, 4'b0000);
        expect_idle();

        // Fairness: requester 0 holds, requester 2 asks once -> 0,2,0.
        do_reset();
        iReq = 4'b0101;
        expect_box(0, 10, 20, 1, 4'b0101);
        expect_box(2, 50, 60, 3, 4'b0001);
        expect_box(0, 10, 20, 1, 4'b0000);
        expect_idle();

        // Clipping at the bottom-right corner.
        do_reset();
        set_box(0, 318, 238, 5);
        iReq = 4'b0001;
        expect_box(0, 318, 238, 5, 4'b0000);
        expect_idle();

        // x wraps past 511: nothing plotted, oX wraps modulo 512.
        set_box(1, 510, 10, 7);
        iReq = 4'b0010;
        expect_box(1, 510, 10, 7, 4'b0000);
        expect_idle();

        // Reset mid-box: abort, then requester 0 wins again from pixel 0.
        do_reset();
        set_box(0, 100, 50, 2);
        set_box(1, 30, 40, 2);
        iReq = 4'b0011;
        tick();
        check("r_grant", 32'(oGrant), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("r_x", 32'(oX), 32'(100 + k % 4));
        end
        iReset = 1'b1;
        #1;
        check("r_async_plot", 32'(oPlot), 32'd0);
        check("r_async_busy", 32'(oBusy), 32'd0);
        check("r_async_xyc", 32'({oX, oY, oColour}), 32'd0);
        tick();
        check("r_hold_plot", 32'(oPlot), 32'd0);
        iReset = 1'b0;
        expect_box(0, 100, 50, 2, 4'b0010);
        expect_box(1, 30, 40, 2, 4'b0000);
        expect_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
